// File: rtl/instr_trace_writer.sv
// ---------------------------------------------------------------------------
// instr_trace_writer
//
// Snoops decoder timing and, when an instruction completes, snapshots its
// opcode plus the eight architectural registers into a small record FIFO.
// Each 72-bit record {opcode, A, B, C, D, E, H, L, F} is streamed out MSB
// first as 9 bytes over a valid/ready byte interface. The byte layout is the
// same as the CPU test-vector files, so hardware runs can be diffed directly
// against simulation vectors.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   t_cycle      decoder T-cycle index
//   m_cycle      decoder current M-cycle
//   m_count      decoder M-cycle count of the current instruction
//   hold         decoder hold/stall
//   instruction  opcode of the executing instruction
//   regs         {A,B,C,D,E,H,L,F}, with A in [63:56]
//   enable       tracing enable, sampled at each capture point
//   out_data     stream byte
//   out_valid    out_data is valid
//   out_ready    sink accepts the byte
//   out_last     high with the 9th (F) byte of a record
//   overflow     sticky: at least one record was dropped
//   drop_count   dropped records, saturating at 255
//   rec_count    records accepted into the FIFO, wrapping
//   done         STOP_OP record accepted; capture is disabled until reset
// ---------------------------------------------------------------------------
module instr_trace_writer #(
   parameter int         DEPTH   = 4,
   parameter logic [7:0] STOP_OP = 8'h10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  t_cycle,
   input  logic [2:0]  m_cycle,
   input  logic [2:0]  m_count,
   input  logic        hold,
   input  logic [7:0]  instruction,
   input  logic [63:0] regs,
   input  logic        enable,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        overflow,
   output logic [7:0]  drop_count,
   output logic [15:0] rec_count,
   output logic        done
);

   localparam int AW = $clog2(DEPTH);

   logic [71:0] mem_r [DEPTH];
   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   logic [3:0]  idx_r;
   logic        cap_q_r;
   logic        overflow_r;
   logic [7:0]  drop_count_r;
   logic [15:0] rec_count_r;
   logic        done_r;

   logic        cap_s;
   logic        cap_edge_s;
   logic        empty_s;
   logic        full_s;
   logic        xfer_s;
   logic        pop_s;
   logic        take_s;
   logic        push_s;
   logic        drop_s;
   logic [71:0] head_s;
   logic [7:0]  byte_s;

   // Capture detection and FIFO status; m_count - m_cycle wraps in 3 bits.
   always_comb begin
      cap_s      = (t_cycle == 2'b11) && ((m_count - m_cycle) == 3'd1) && !hold;
      cap_edge_s = cap_s && !cap_q_r;
      empty_s    = (wr_ptr_r == rd_ptr_r);
      full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      xfer_s     = !empty_s && out_ready;
      pop_s      = xfer_s && (idx_r == 4'd8);
      take_s     = cap_edge_s && enable && !done_r;
      // A full FIFO still accepts when the head leaves on this same edge.
      push_s     = take_s && (!full_s || pop_s);
      drop_s     = take_s && !push_s;
   end

   // Select the current byte of the head record, opcode first.
   always_comb begin
      head_s = mem_r[rd_ptr_r[AW-1:0]];
      case (idx_r)
         4'd0:    byte_s = head_s[71:64];
         4'd1:    byte_s = head_s[63:56];
         4'd2:    byte_s = head_s[55:48];
         4'd3:    byte_s = head_s[47:40];
         4'd4:    byte_s = head_s[39:32];
         4'd5:    byte_s = head_s[31:24];
         4'd6:    byte_s = head_s[23:16];
         4'd7:    byte_s = head_s[15:8];
         4'd8:    byte_s = head_s[7:0];
         default: byte_s = 8'h00;
      endcase
   end

   // Stream outputs, all derived from registered state only.
   always_comb begin
      out_valid = !empty_s;
      if (!empty_s) begin
         out_data = byte_s;
         out_last = (idx_r == 4'd8);
      end else begin
         out_data = 8'h00;
         out_last = 1'b0;
      end
      overflow   = overflow_r;
      drop_count = drop_count_r;
      rec_count  = rec_count_r;
      done       = done_r;
   end

   // Record storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 72'h0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {instruction, regs};
      end
   end

   // FIFO pointers and serializer byte index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         idx_r    <= 4'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
            idx_r    <= 4'd0;
         end else if (xfer_s) begin
            idx_r    <= idx_r + 4'd1;
         end
      end
   end

   // Capture edge history, statistics and the stop latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_q_r      <= 1'b0;
         overflow_r   <= 1'b0;
         drop_count_r <= 8'h00;
         rec_count_r  <= 16'h0000;
         done_r       <= 1'b0;
      end else begin
         cap_q_r <= cap_s;
         if (push_s) begin
            rec_count_r <= rec_count_r + 16'd1;
            if (instruction == STOP_OP) begin
               done_r <= 1'b1;
            end
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_count_r != 8'hFF) begin
               drop_count_r <= drop_count_r + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_trace_writer.sv
module tb_instr_trace_writer;

   logic        clk;
   logic        rst;
   logic [1:0]  t_cycle;
   logic [2:0]  m_cycle;
   logic [2:0]  m_count;
   logic        hold;
   logic [7:0]  instruction;
   logic [63:0] regs;
   logic        enable;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        overflow;
   logic [7:0]  drop_count;
   logic [15:0] rec_count;
   logic        done;

   instr_trace_writer #(.DEPTH(4), .STOP_OP(8'h10)) dut (
      .clk(clk), .rst(rst), .t_cycle(t_cycle), .m_cycle(m_cycle),
      .m_count(m_count), .hold(hold), .instruction(instruction), .regs(regs),
      .enable(enable), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .overflow(overflow),
      .drop_count(drop_count), .rec_count(rec_count), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [8:0]  byte_q [$];   // {last, data} of every transferred byte
   logic [71:0] exp_q  [$];   // records expected on the stream

   typedef struct {
      logic [1:0]  t;
      logic [2:0]  mc;
      logic [2:0]  mk;
      logic        hd;
      logic        en;
      logic [7:0]  op;
      logic [63:0] rg;
      logic        exp_push;
   } vec_t;

   vec_t vt [8];

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Byte monitor: samples mid-cycle, records transfers, checks hold stability.
   logic       stall = 1'b0;
   logic [7:0] sdata = 8'h00;
   logic       slast = 1'b0;
   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("stall_data", {64'h0, out_data}, {64'h0, sdata});
            check("stall_last", {71'h0, out_last}, {71'h0, slast});
         end
         if (out_valid && out_ready) byte_q.push_back({out_last, out_data});
         stall = out_valid && !out_ready;
         sdata = out_data;
         slast = out_last;
      end
   end

   task automatic idle_inputs();
      t_cycle = 2'b00; m_cycle = 3'd0; m_count = 3'd0; hold = 1'b0; enable = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      byte_q.delete();
      exp_q.delete();
   endtask

   // Called at a negedge: one cycle with cap high, then one idle cycle.
   task automatic do_instr(input logic [7:0] op, input logic [63:0] rg);
      instruction = op; regs = rg;
      t_cycle = 2'b11; m_cycle = 3'd0; m_count = 3'd1; hold = 1'b0;
      @(negedge clk);
      t_cycle = 2'b00;
      @(negedge clk);
   endtask

   task automatic check_drain(input string name);
      logic [71:0] rec;
      check({name, "_nbytes"}, 72'(byte_q.size()), 72'(9 * exp_q.size()));
      if (byte_q.size() == 9 * exp_q.size()) begin
         for (int r = 0; r < exp_q.size(); r++) begin
            rec = exp_q[r];
            for (int b = 0; b < 9; b++) begin
               check($sformatf("%s_r%0d_b%0d", name, r, b), {63'h0, byte_q[9*r+b]},
                     {63'h0, (b == 8), rec[71-8*b -: 8]});
            end
         end
      end
      byte_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int exp_rec;
      logic [3:0] pat;

      vt[0] = '{2'b11, 3'd0, 3'd1, 1'b0, 1'b1, 8'h11, 64'h0102030405060708, 1'b1};
      vt[1] = '{2'b11, 3'd7, 3'd0, 1'b0, 1'b1, 8'h12, 64'h1112131415161718, 1'b1};
      vt[2] = '{2'b11, 3'd2, 3'd3, 1'b0, 1'b1, 8'h13, 64'h2122232425262728, 1'b1};
      vt[3] = '{2'b11, 3'd1, 3'd3, 1'b0, 1'b1, 8'h99, 64'hDEADBEEFDEADBEEF, 1'b0};
      vt[4] = '{2'b10, 3'd0, 3'd1, 1'b0, 1'b1, 8'h98, 64'hDEADBEEFDEADBEEF, 1'b0};
      vt[5] = '{2'b11, 3'd0, 3'd1, 1'b1, 1'b1, 8'h97, 64'hDEADBEEFDEADBEEF, 1'b0};
      vt[6] = '{2'b11, 3'd0, 3'd1, 1'b0, 1'b0, 8'h96, 64'hDEADBEEFDEADBEEF, 1'b0};
      vt[7] = '{2'b11, 3'd5, 3'd6, 1'b0, 1'b1, 8'h14, 64'h3132333435363738, 1'b1};

      rst = 1'b0; out_ready = 1'b1; instruction = 8'h00; regs = 64'h0;
      idle_inputs();

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_valid", {71'h0, out_valid}, 72'h0);
      check("rst_data", {64'h0, out_data}, 72'h0);
      check("rst_last", {71'h0, out_last}, 72'h0);
      check("rst_ovf", {71'h0, overflow}, 72'h0);
      check("rst_drop", {64'h0, drop_count}, 72'h0);
      check("rst_rec", {56'h0, rec_count}, 72'h0);
      check("rst_done", {71'h0, done}, 72'h0);

      // Basic record after reset; first byte visible the cycle after capture.
      rst = 1'b1;
      @(negedge clk);
      instruction = 8'h3E; regs = 64'h0A00000000000000;
      t_cycle = 2'b11; m_cycle = 3'd0; m_count = 3'd1;
      @(negedge clk);
      t_cycle = 2'b00;
      check("lat_valid", {71'h0, out_valid}, 72'h1);
      check("lat_byte0", {64'h0, out_data}, 72'h3E);
      exp_q.push_back({8'h3E, 64'h0A00000000000000});
      repeat (12) @(negedge clk);
      check("basic_rec", {56'h0, rec_count}, 72'd1);
      check_drain("basic");

      // Table of capture-condition vectors.
      do_reset();
      exp_rec = 0;
      for (int i = 0; i < 8; i++) begin
         t_cycle = vt[i].t; m_cycle = vt[i].mc; m_count = vt[i].mk;
         hold = vt[i].hd; enable = vt[i].en; instruction = vt[i].op; regs = vt[i].rg;
         @(negedge clk);
         idle_inputs();
         repeat (12) @(negedge clk);
         if (vt[i].exp_push) begin
            exp_rec++;
            exp_q.push_back({vt[i].op, vt[i].rg});
         end
         check($sformatf("tbl%0d_rec", i), {56'h0, rec_count}, 72'(exp_rec));
         check($sformatf("tbl%0d_drop", i), {64'h0, drop_count}, 72'h0);
      end
      check_drain("tbl");

      // Stalled last T-cycle yields a single record.
      do_reset();
      instruction = 8'h55; regs = 64'h5555AAAA5555AAAA;
      t_cycle = 2'b11; m_cycle = 3'd0; m_count = 3'd1; hold = 1'b1;
      repeat (3) @(negedge clk);
      hold = 1'b0;
      repeat (3) @(negedge clk);
      idle_inputs();
      repeat (12) @(negedge clk);
      check("stall_rec", {56'h0, rec_count}, 72'd1);
      exp_q.push_back({8'h55, 64'h5555AAAA5555AAAA});
      check_drain("stall");

      // Backpressure with ready pattern 1,0,0,1.
      do_reset();
      out_ready = 1'b0;
      do_instr(8'h04, 64'h0000000000000100);
      do_instr(8'h05, 64'h0000000000000200);
      exp_q.push_back({8'h04, 64'h0000000000000100});
      exp_q.push_back({8'h05, 64'h0000000000000200});
      pat = 4'b1001;
      for (int i = 0; i < 48; i++) begin
         out_ready = pat[3 - (i % 4)];
         @(negedge clk);
      end
      out_ready = 1'b1;
      check_drain("bp");

      // Overflow: six captures into a four-deep FIFO with the sink stalled.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         do_instr(8'h20 + 8'(i), {8{8'h40 + 8'(i)}});
         if (i < 4) exp_q.push_back({8'h20 + 8'(i), {8{8'h40 + 8'(i)}}});
      end
      check("ovf_rec", {56'h0, rec_count}, 72'd4);
      check("ovf_flag", {71'h0, overflow}, 72'h1);
      check("ovf_drop", {64'h0, drop_count}, 72'd2);
      out_ready = 1'b1;
      repeat (45) @(negedge clk);
      check_drain("ovf");

      // Full FIFO, capture coincides with the head's 9th-byte handshake.
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_instr(8'h60 + 8'(i), {8{8'h70 + 8'(i)}});
         exp_q.push_back({8'h60 + 8'(i), {8{8'h70 + 8'(i)}}});
      end
      out_ready = 1'b1;
      repeat (8) @(negedge clk);
      check("fp_last", {71'h0, out_last}, 72'h1);
      do_instr(8'h77, 64'h7777777777777777);
      exp_q.push_back({8'h77, 64'h7777777777777777});
      check("fp_ovf", {71'h0, overflow}, 72'h0);
      check("fp_rec", {56'h0, rec_count}, 72'd5);
      repeat (45) @(negedge clk);
      check_drain("fp");

      // STOP opcode ends capture; later captures are neither kept nor dropped.
      do_reset();
      do_instr(8'h00, 64'h0102030405060708);
      do_instr(8'h10, 64'h1020304050607080);
      do_instr(8'h00, 64'hFFFFFFFFFFFFFFFF);
      exp_q.push_back({8'h00, 64'h0102030405060708});
      exp_q.push_back({8'h10, 64'h1020304050607080});
      repeat (20) @(negedge clk);
      check("stop_rec", {56'h0, rec_count}, 72'd2);
      check("stop_done", {71'h0, done}, 72'h1);
      check("stop_drop", {64'h0, drop_count}, 72'h0);
      check("stop_ovf", {71'h0, overflow}, 72'h0);
      check_drain("stop");

      // Asynchronous reset in the middle of a record.
      do_instr(8'h00, 64'h0);
      do_reset();
      do_instr(8'hAB, 64'hABABABABABABABAB);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_valid", {71'h0, out_valid}, 72'h0);
      check("arst_rec", {56'h0, rec_count}, 72'h0);
      check("arst_done", {71'h0, done}, 72'h0);
      byte_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      check("arst_valid_after", {71'h0, out_valid}, 72'h0);
      check_drain("arst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_trace_writer.md
Name: instr_trace_writer

Overview:
- Hardware-side producer of per-instruction architectural trace records, using the same format as the CPU test-vector files: {opcode[7:0], A,B,C,D,E,H,L,F} = 72 bits.
- Sits beside the decoder and register file in top.
- Snoops instruction-completion timing, snapshots the opcode and the eight 8-bit registers into a small record FIFO, and streams each record out as 9 bytes over a valid/ready byte interface.
- The stream feeds an external logger/UART so silicon or FPGA runs can be diffed against the same expected vectors used in simulation.

Parameters:
DEPTH, 4, record FIFO depth in 72-bit records (power of two, >=2)
STOP_OP, 8'h10, opcode that ends tracing after it is recorded

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
t_cycle  input  2  decoder T-cycle index
m_cycle  input  3  decoder current M-cycle
m_count  input  3  decoder M-cycle count of current instruction
hold  input  1  decoder hold/stall
instruction  input  8  opcode of executing instruction
regs  input  64  {A,B,C,D,E,H,L,F}, A in [63:56]
enable  input  1  tracing enable; sampled at each capture point
out_data  output  8  stream byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts byte
out_last  output  1  high with the 9th (F) byte of a record
overflow  output  1  sticky: a record was dropped
drop_count  output  8  dropped records, saturates at 255
rec_count  output  16  records accepted into FIFO, wraps at 65535->0
done  output  1  STOP_OP record accepted; capture disabled

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FIFO empty, byte index 0, cap_q 0. out_valid drops immediately, without waiting for a clock edge. A partially sent record is discarded.
- Capture condition: cap = (t_cycle==2'b11) && (m_count - m_cycle == 3'd1) && !hold, evaluated on 3-bit wrapped arithmetic.
- Capture fires only on the rising edge of cap: cap && !cap_q, where cap_q is registered cap. A stalled last T-cycle therefore yields exactly one record.
- On a capture edge with enable=1 and done=0:
  - If the FIFO is not full, or will free a slot this cycle (head record's 9th byte handshakes in the same cycle), write {instruction, regs} and increment rec_count.
  - Otherwise drop the record, set overflow, and increment drop_count (saturating).
- done: set on the same edge that accepts a record whose opcode == STOP_OP. While done=1, further captures are ignored and not counted as drops. Queued records still drain. Only reset clears done.
- enable=0 at a capture edge: no record, no drop.
- Output serializer:
  - Head record is sent MSB first: byte0 = opcode, then A, B, C, D, E, H, L, F.
  - out_valid = FIFO non-empty. out_data = head[71 - 8*idx -: 8].
  - out_last = out_valid && idx==8.
  - A byte transfers on a rising edge with out_valid && out_ready; idx then increments.
  - On the idx==8 transfer: idx returns to 0 and the record is popped.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - Consecutive records stream back to back, with no bubble.
- Latency: a record captured at edge N gives out_valid=1 with byte0 after edge N (visible in cycle N+1), provided the FIFO was empty. Minimum 9 cycles per record at out_ready=1.
- Pointers: log2(DEPTH)+1 bits. full = MSBs differ and the rest are equal. empty = pointers equal.
- Simultaneous push and pop when full is legal and leaves occupancy unchanged.

Test Plan:
- Reset: hold rst=0 with out_ready=1 -> all outputs 0. Release rst, run one instruction 0x3E with regs=64'h0A00000000000000, enable=1 -> stream 3E,0A,00,00,00,00,00,00,00. out_last only on the 9th byte. rec_count=1.
- Stall: hold=1 for 3 cycles during the last T-cycle, then release with cap held -> exactly one record, rec_count=1.
- Backpressure: toggle out_ready in the pattern 1,0,0,1 over 2 records (0x04 regs=...0100, 0x05 regs=...0200) -> 18 bytes in order. Data is stable during every ready=0 cycle.
- Overflow: out_ready=0, 6 instructions with DEPTH=4 -> rec_count=4, overflow=1, drop_count=2. Then out_ready=1 -> exactly 36 bytes, of the first 4 records.
- Full plus simultaneous pop: FIFO full, and a capture coincides with the head record's 9th-byte handshake -> record accepted, overflow stays 0.
- STOP: instruction sequence 0x00, 0x10, 0x00 -> 2 records out, last opcode 0x10, done=1, drop_count=0. Asserting rst mid-record clears out_valid asynchronously, and no stale bytes appear after release.
